// File: rtl/fwuart_rx_fifo.sv
// UART receive FIFO, first-word-fall-through, with fill level and overrun.
// Also raises threshold and character-timeout interrupts.
module fwuart_rx_fifo #(
  parameter  int DEPTH         = 16,
  parameter  int TIMEOUT_CHARS = 4,
  localparam int AW            = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clock_x16,
  input  logic [7:0]    t_dat,
  input  logic          t_valid,
  output logic          t_ready,
  output logic [7:0]    i_dat,
  output logic          i_valid,
  input  logic          i_ready,
  input  logic          flush,
  input  logic [AW:0]   thresh,
  input  logic          overrun_clr,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty,
  output logic          overrun,
  output logic          irq_thresh,
  output logic          irq_timeout
);

  localparam logic [AW:0]   LV_ONE  = 1;
  localparam logic [AW:0]   LV_FULL = DEPTH[AW:0];
  localparam logic [AW-1:0] PT_ONE  = 1;
  localparam logic [11:0]   LIMIT   = 12'(TIMEOUT_CHARS * 160);
  localparam logic [11:0]   TC_ONE  = 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_lvl;
  logic          r_ovr;
  logic [11:0]   r_tcnt;

  logic w_push;
  logic w_pop;
  logic w_wr;
  logic w_ovf;
  logic w_full;
  logic w_empty;

  assign w_full  = (r_lvl == LV_FULL);
  assign w_empty = (r_lvl == '0);
  assign w_push  = t_valid;
  assign w_pop   = !w_empty && i_ready;
  // A full FIFO still takes the byte when the head leaves on the same edge.
  assign w_wr    = w_push && !flush && (!w_full || w_pop);
  assign w_ovf   = w_push && !flush && w_full && !w_pop;

  always_ff @(posedge clock) begin
    if (reset && w_wr) begin
      r_mem[r_wr_ptr] <= t_dat;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_lvl    <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_lvl    <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + PT_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PT_ONE;
      end
      if (w_wr && !w_pop) begin
        r_lvl <= r_lvl + LV_ONE;
      end else if (w_pop && !w_wr) begin
        r_lvl <= r_lvl - LV_ONE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_ovr <= 1'b0;
    end else if (w_ovf) begin
      r_ovr <= 1'b1;
    end else if (overrun_clr) begin
      r_ovr <= 1'b0;
    end
  end

  // Idle timer in x16 strobes; any FIFO activity restarts it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_tcnt <= '0;
    end else if (flush || w_push || w_pop || w_empty) begin
      r_tcnt <= '0;
    end else if (clock_x16 && (r_tcnt != LIMIT)) begin
      r_tcnt <= r_tcnt + TC_ONE;
    end
  end

  assign t_ready     = 1'b1;
  assign i_dat       = r_mem[r_rd_ptr];
  assign i_valid     = !w_empty;
  assign level       = r_lvl;
  assign full        = w_full;
  assign empty       = w_empty;
  assign overrun     = r_ovr;
  assign irq_thresh  = (thresh != '0) && (r_lvl >= thresh);
  assign irq_timeout = (r_tcnt == LIMIT);

endmodule
